// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Handshaked sequential ALU. ADD, SUB, AND, OR and XOR finish in
//            one cycle. SHL and SHR shift one bit per cycle. The result and
//            the carry/zero/ovf flags are registered.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready  - operand handshake (a, b, op)
//            out_valid/out_ready- result handshake (result, carry, zero, ovf)
// Params   : WIDTH - operand/result width (>=2)
//            SHW   - shift-amount width; the shift amount is b[SHW-1:0]
// Options  : `define ALU_SEQ_SAT_EN -> ADD/SUB saturate unsigned
//            (ADD overflow gives all-ones, SUB borrow gives zero).
//            carry and ovf still report the raw, unsaturated arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;

  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
  localparam logic [SHW-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_right_q, dir_right_d;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;

  // Widened by one bit so the top bit is the carry (ADD) or borrow (SUB).
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHW-1:0];

  // Single-cycle operations. ovf always uses the unsaturated result.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SEQ_SAT_EN
        alu_res   = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        alu_res   = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        alu_carry = diff[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SEQ_SAT_EN
        alu_res   = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        alu_res   = diff[WIDTH-1:0];
`endif
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      default: alu_res = '0;  // reserved op: zero result, flags clear
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    dir_right_d = dir_right_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if ((op == OP_SHL) || (op == OP_SHR)) begin
            result_d    = a;
            carry_d     = 1'b0;
            ovf_d       = 1'b0;
            cnt_d       = shamt;
            dir_right_d = (op == OP_SHR);
            // A zero shift amount completes immediately with the operand.
            state_d     = (shamt == CNT_ZERO) ? S_DONE : S_SHIFT;
          end else begin
            result_d = alu_res;
            carry_d  = alu_carry;
            ovf_d    = alu_ovf;
            state_d  = S_DONE;
          end
          zero_d = (result_d == '0);
        end else if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        // Shift amounts beyond WIDTH keep shifting zeros, so the result
        // ends up 0 and carry ends up 0 without special-casing.
        if (dir_right_q) begin
          result_d = {1'b0, result_q[WIDTH-1:1]};
          carry_d  = result_q[0];
        end else begin
          result_d = {result_q[WIDTH-2:0], 1'b0};
          carry_d  = result_q[WIDTH-1];
        end
        zero_d = (result_d == '0);
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      dir_right_q <= dir_right_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (WIDTH=8). Directed cases plus
//            random operations checked against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int W   = 8;
  localparam int SHW = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W), .SHW(SHW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's definition.
  task automatic model(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] r, output logic c, output logic v, output int lat);
    int sh;
    int sa;
    int sb;
    int s;
    logic [2*W-1:0] ext;
    sh  = int'(bv[SHW-1:0]);
    sa  = $signed(av);
    sb  = $signed(bv);
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    lat = 1;
    case (o)
      3'd0: begin
        s = int'(av) + int'(bv);
        r = W'(s);
        c = (s > 255);
        v = ((sa + sb) > 127) || ((sa + sb) < -128);
`ifdef ALU_SEQ_SAT_EN
        if (c) r = 8'hFF;
`endif
      end
      3'd1: begin
        s = int'(av) - int'(bv);
        r = W'(s);
        c = (av < bv);
        v = ((sa - sb) > 127) || ((sa - sb) < -128);
`ifdef ALU_SEQ_SAT_EN
        if (c) r = 8'h00;
`endif
      end
      3'd2: r = av & bv;
      3'd3: r = av | bv;
      3'd4: r = av ^ bv;
      3'd5: begin
        ext = {{W{1'b0}}, av} << sh;
        r   = ext[W-1:0];
        c   = (sh != 0) ? ext[W] : 1'b0;
        lat = 1 + sh;
      end
      3'd6: begin
        r   = av >> sh;
        c   = (sh != 0) ? av[sh-1] : 1'b0;
        lat = 1 + sh;
      end
      default: r = '0;
    endcase
  endtask

  // Issue one op at a negedge (block must be ready) and wait for its result.
  // Returns at the negedge where out_valid is first seen high.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] er;
    logic         ec;
    logic         ev;
    int           elat;
    int           lat;
    model(o, av, bv, er, ec, ev, elat);
    check({tag, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    op = o;
    a  = av;
    b  = bv;
    @(negedge clk);
    lat = 1;
    // Scramble inputs: the block must have captured them at accept.
    in_valid = 1'b0;
    a  = W'($urandom);
    b  = W'($urandom);
    op = 3'($urandom);
    while (!out_valid && lat < 40) begin
      check({tag, ".busy"}, in_ready, 0);
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, elat);
    check({tag, ".result"}, result, er);
    check({tag, ".carry"}, carry, ec);
    check({tag, ".zero"}, zero, (er == '0));
    check({tag, ".ovf"}, ovf, ev);
  endtask

  logic [W-1:0] held_r;
  logic [3:0]   held_f;
  logic         saw_valid;

  initial begin
    // Reset state
    #2;
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.result", result, 0);
    check("rst.flags", {carry, zero, ovf}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic/logic cases, issued back-to-back
    run_op("add_f0_20", 3'd0, 8'hF0, 8'h20);
    run_op("add_7f_01", 3'd0, 8'h7F, 8'h01);
    run_op("sub_05_07", 3'd1, 8'h05, 8'h07);
    run_op("sub_80_01", 3'd1, 8'h80, 8'h01);
    run_op("xor_5a_5a", 3'd4, 8'h5A, 8'h5A);
    run_op("shl_e1_03", 3'd5, 8'hE1, 8'h03);
    run_op("shr_81_00", 3'd6, 8'h81, 8'h00);
    run_op("rsv_111", 3'd7, 8'hAB, 8'hCD);
    run_op("shr_80_07", 3'd6, 8'h80, 8'h07);
    run_op("shl_ff_0f", 3'd5, 8'hFF, 8'h0F);

    // Consume and return to idle
    @(negedge clk);
    check("idle.out_valid", out_valid, 0);

    // Back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    run_op("bp_add", 3'd0, 8'h7F, 8'h01);
    held_r = result;
    held_f = {out_valid, carry, zero, ovf};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.result_hold", result, 8'h80);
      check("bp.flags_hold", {out_valid, carry, zero, ovf}, 4'b1001);
      check("bp.in_ready", in_ready, 0);
    end
    // Handshake and new accept in the same cycle: no bubble
    out_ready = 1'b1;
    #1;
    check("bp.accept_ready", in_ready, 1);
    in_valid = 1'b1;
    op = 3'd2;
    a  = 8'h0F;
    b  = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.and.out_valid", out_valid, 1);
    check("bp.and.result", result, 8'h0C);
    check("bp.and.flags", {carry, zero, ovf}, 3'b000);
    @(negedge clk);
    check("bp.drain", out_valid, 0);

    // Reset in the middle of a long shift
    in_valid = 1'b1;
    op = 3'd6;
    a  = 8'hFF;
    b  = 8'h07;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.out_valid", out_valid, 0);
    check("abort.result", result, 0);
    check("abort.flags", {carry, zero, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort.in_ready", in_ready, 1);
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("abort.no_result", saw_valid, 0);

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      run_op("rand", 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    end
    @(negedge clk);
    check("end.out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 8-bit combinational ALU.
- Performs ADD, SUB, AND, OR and XOR, plus iterative logical shifts left and right.
- Returns registered result and flags (carry, zero, overflow) through valid/ready interfaces.
- Sits between an operand-issuing controller and a result consumer; throughput is one op per cycle for non-shift ops.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- SHW, $clog2(WIDTH), shift-amount width; the shift amount is B[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/op valid
- in_ready  output  1  block can accept an op this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B / shift amount
- op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 reserved
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- carry  output  1  carry / borrow / last bit shifted out
- zero  output  1  result == 0
- ovf  output  1  signed overflow (ADD/SUB only)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, carry=0, zero=0, ovf=0, shift counter=0.
- FSM states: IDLE, SHIFT, DONE.
- Accept: an op is accepted on in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is 0 in SHIFT.
- IDLE/DONE accept of op 000-100 or 111: result and flags are registered that edge. Next state is DONE, so out_valid rises 1 cycle after accept.
- IDLE/DONE accept of SHL/SHR with shamt=B[SHW-1:0]:
  - shamt==0: result=A, carry=0, go to DONE.
  - otherwise: load A, counter=shamt, go to SHIFT.
- SHIFT: each cycle shift 1 bit (zero fill) and capture the bit shifted out into carry. Decrement counter; when it reaches 1, go to DONE after that shift. Latency = 1 + shamt cycles.
- DONE: out_valid=1; result and flags held stable while out_ready=0.
  - out_ready=1 without a new accept: go to IDLE, out_valid=0 next cycle.
  - Handshake and new accept in the same cycle: load the new op, no bubble.
- ADD: {carry,result}=A+B, WIDTH+1-bit sum. ovf = (A[MSB]==B[MSB]) && (result[MSB]!=A[MSB]).
- SUB: {carry,result}=A-B, so carry=1 means borrow (A<B unsigned). ovf = (A[MSB]!=B[MSB]) && (result[MSB]!=A[MSB]).
- AND/OR/XOR: carry=0, ovf=0.
- Shifts: ovf=0. Shift amounts are modulo 2^SHW; for non-power-of-2 WIDTH, shamt>=WIDTH yields result 0.
- Op 111: result=0, carry=0, ovf=0, zero=1.
- zero is computed from the final registered result for every op.
- Inputs a/b/op are sampled only at accept; later changes are ignored.
- Reset asserted mid-SHIFT or in DONE: abort immediately to reset values; the pending result is lost.

Optional Feature:
- Macro: ALU_SEQ_SAT_EN.
- Defined: ADD and SUB saturate unsigned.
  - ADD with carry -> result all-ones.
  - SUB with borrow -> result 0.
  - carry still reports the raw carry/borrow; ovf is unchanged (computed on the unsaturated result); zero is computed on the saturated result.
- Not defined: wrap-around arithmetic as above, and no saturation logic is synthesised.

Test Plan:
- WIDTH=8, ADD a=F0 b=20 -> result 10, carry1, zero0, ovf0. ADD a=7F b=01 -> result 80, carry0, ovf1. Each has out_valid 1 cycle after accept.
- SUB a=05 b=07 -> result FE, carry1, ovf0. SUB a=80 b=01 -> result 7F, carry0, ovf1. XOR a=5A b=5A -> result 00, zero1.
- SHL a=E1 b=03 -> in_ready low 3 cycles, out_valid at accept+4, result 08, carry1. SHR a=81 b=00 -> result 81, carry0, latency 1.
- Back-pressure: ADD result pending with out_ready=0 for 5 cycles -> result/flags stable, in_ready=0. Then out_ready=1 with in_valid=1 (AND a=0F b=3C) -> next cycle result 0C, out_valid stays 1.
- Reset mid-op: SHR a=FF b=07; rst_n low at cycle 3 -> all outputs 0, in_ready=1 after release. No out_valid from the aborted op.
- With ALU_SEQ_SAT_EN: ADD F0+20 -> result FF, carry1. SUB 05-07 -> result 00, carry1, zero1. Op 111 in either build -> result 00, zero1.
